object_packer: RTL
==================

Name: object_packer

Overview:
- Inverse of the per-shape object converters: packs drawn endpoint geometry into the 115-bit object_props word consumed downstream by the circle, line and rect converters and the physics engine.
- Sits between the stroke/shape detection stage and the object table writer.
- Circle radius comes from a center point and a rim point, using an iterative integer square root. Line and rect are packed with a single-cycle path.

Parameters:
- ROOT_BITS, 12, width of the sqrt result; also the number of ROOT iterations.
- RAD_BITS, 24, width of the radicand register (2*ROOT_BITS).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- shape_in  input  2  00 circle, 01 line, 10 rect, 11 reserved
- is_static_in  input  1  static-object flag
- x_in_1  input  11  point 0 x (circle center / line start / rect corner)
- y_in_1  input  10  point 0 y
- x_in_2  input  11  point 1 x (circle rim / line end / rect adjacent corner)
- y_in_2  input  10  point 1 y
- y_in_3  input  10  rect only: y of third corner; ignored otherwise
- valid_in  input  1  request strobe
- ready_out  output  1  high when IDLE and rst_in=1
- object_props  output  115  packed object word
- valid_out  output  1  object_props valid; held until accepted
- ready_in  input  1  downstream accept
- error_out  output  1  qualifies valid_out; reserved shape

Behaviour:
- Reset (rst_in=0 at posedge): state=IDLE; valid_out=0, error_out=0, object_props=0. ready_out=0 while rst_in=0.
- Reset mid-operation aborts any transaction; no output is produced for it.
- Accept occurs when valid_in && ready_out at a posedge; all inputs are latched on that edge.
- Packing, common to all shapes:
  - [114] = is_static
  - [113:112] = shape
  - [31:0] = 0
  - every unused field = 0
- Circle packing:
  - [111:96] = zero-extended x1
  - [95:80] = zero-extended y1
  - [47:32] = zero-extended radius
  - radius = floor(sqrt(dx*dx + dy*dy)), with dx = x2-x1 and dy = y2-y1 (signed, 12/11 bits).
- Line packing:
  - [111:96] = {1'b0, x1, 4'b0}
  - [95:80] = {1'b0, y1, 5'b0}
  - [63:48] = zero-extended x2
  - [47:32] = zero-extended y2
- Rect packing:
  - [111:96] and [95:80] as for line
  - [79:64] = dx1 = x2-x1, signed 16
  - [63:48] = dy1 = y2-y1, signed 16
  - [47:32] = dy2 = y3-y2, signed 16
  - Invariant: the rect converter recovers y2' = y1+dy1+dy2 = y3.
- State machine:
  - IDLE: on accept, line/rect/reserved go to OUT; circle goes to SQUARE.
  - SQUARE (1 cycle): radicand <= dx^2 + dy^2, which is at most 5,236,738 (< 2^23) and is zero-extended to RAD_BITS. root=0, remainder=0, goes to ROOT.
  - ROOT: restoring digit-by-digit sqrt, one result bit per cycle for ROOT_BITS cycles (counter 0..11). After the last bit, goes to OUT.
  - OUT: valid_out=1 with object_props stable. On ready_in, the next state is IDLE and valid_out=0.
- Latency from the accept edge to valid_out high:
  - line, rect, reserved: 1 cycle
  - circle: 1 + 1 + 12 = 14 cycles
- Throughput: one transaction per (latency + 1) cycles minimum, because ready_out is low outside IDLE. New requests are not accepted in OUT even if ready_in is high on the same edge; they are accepted the cycle after.
- Reserved shape 11: object_props=0, error_out=1 with valid_out. error_out clears when the output is accepted.
- Backpressure: in OUT with ready_in=0, object_props, valid_out and error_out hold indefinitely.
- Degenerate circle (point 1 equal to point 0): radius=0, packed normally with no error.

Test Plan:
- Circle, center (100,200), rim (103,204): object_props[111:96]=100, [95:80]=200, [47:32]=5, [113:112]=00; valid_out exactly 14 cycles after accept.
- Circle max span, (0,0) to (2047,1023): radius=2288 (floor of 2288.39); also check a perfect square, (0,0) to (0,1023): radius=1023.
- Line (10,20)->(300,400), is_static=1: [114]=1, [111:96]=0x00A0, [95:80]=0x0280, [63:48]=300, [47:32]=400; valid_out 1 cycle after accept.
- Rect corner (50,60), adjacent (80,40), y3=100: [79:64]=30, [63:48]=0xFFEC, [47:32]=60; the rect converter fed this word yields y_in_2=100.
- Backpressure and reserved shape:
  - hold ready_in=0 for 5 cycles in OUT: object_props stable and ready_out=0 throughout;
  - shape=11: props=0 and error_out=1 alongside valid_out.
- Reset mid-circle: drive rst_in=0 on ROOT cycle 6 → next edge valid_out=0 and state IDLE. After release, a line request completes normally with no stale circle output.

Source files
------------

// File: rtl/object_packer.sv
// object_packer: packs endpoint geometry into the 115-bit object_props word.
// Circle radius uses a multi-cycle restoring integer square root.
module object_packer #(
    parameter int ROOT_BITS = 12,
    parameter int RAD_BITS  = 24
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [1:0]   shape_in,
    input  logic         is_static_in,
    input  logic [10:0]  x_in_1,
    input  logic [9:0]   y_in_1,
    input  logic [10:0]  x_in_2,
    input  logic [9:0]   y_in_2,
    input  logic [9:0]   y_in_3,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [114:0] object_props,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         error_out
);

    localparam int REM_BITS = ROOT_BITS + 3;
    localparam int CNT_BITS = $clog2(ROOT_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQUARE,
        S_ROOT,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic                r_static;
    logic [10:0]         r_x1;
    logic [9:0]          r_y1;
    logic [10:0]         r_x2;
    logic [9:0]          r_y2;
    logic [RAD_BITS-1:0] r_rad;
    logic [ROOT_BITS-1:0] r_root;
    logic [ROOT_BITS:0]  r_rem;
    logic [CNT_BITS-1:0] r_cnt;
    logic [114:0]        r_props;
    logic                r_valid;
    logic                r_err;

    logic                w_accept;
    logic                w_last;
    logic [15:0]         w_rdx1;
    logic [15:0]         w_rdy1;
    logic [15:0]         w_rdy2;
    logic [11:0]         w_cdx;
    logic [10:0]         w_cdy;
    logic signed [RAD_BITS-1:0] w_cdx_ext;
    logic signed [RAD_BITS-1:0] w_cdy_ext;
    logic signed [RAD_BITS-1:0] w_dx_sq;
    logic signed [RAD_BITS-1:0] w_dy_sq;
    logic [RAD_BITS-1:0] w_rad_sq;
    logic [REM_BITS-1:0] w_rem_sh;
    logic [REM_BITS-1:0] w_trial;
    logic                w_ge;
    logic [ROOT_BITS:0]  w_rem_nx;
    logic [ROOT_BITS-1:0] w_root_nx;
    logic [114:0]        w_props_lr;
    logic [114:0]        w_props_circ;

    assign ready_out    = (r_state == S_IDLE) && rst_in;
    assign w_accept     = valid_in && ready_out;
    assign w_last       = (r_cnt == CNT_BITS'(ROOT_BITS - 1));
    assign object_props = r_props;
    assign valid_out    = r_valid;
    assign error_out    = r_err;

    // Zero-extended 16-bit subtraction yields the two's complement delta.
    assign w_rdx1 = {5'b0, x_in_2} - {5'b0, x_in_1};
    assign w_rdy1 = {6'b0, y_in_2} - {6'b0, y_in_1};
    assign w_rdy2 = {6'b0, y_in_3} - {6'b0, y_in_2};

    assign w_cdx     = {1'b0, r_x2} - {1'b0, r_x1};
    assign w_cdy     = {1'b0, r_y2} - {1'b0, r_y1};
    assign w_cdx_ext = {{(RAD_BITS-12){w_cdx[11]}}, w_cdx};
    assign w_cdy_ext = {{(RAD_BITS-11){w_cdy[10]}}, w_cdy};
    assign w_dx_sq   = w_cdx_ext * w_cdx_ext;
    assign w_dy_sq   = w_cdy_ext * w_cdy_ext;
    assign w_rad_sq  = w_dx_sq + w_dy_sq;

    // One restoring sqrt step: bring down two radicand bits, try 4*root+1.
    assign w_rem_sh  = {r_rem, r_rad[RAD_BITS-1 -: 2]};
    assign w_trial   = {1'b0, r_root, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_nx  = (ROOT_BITS+1)'(w_ge ? w_rem_sh - w_trial : w_rem_sh);
    assign w_root_nx = {r_root[ROOT_BITS-2:0], w_ge};

    always_comb begin
        w_props_lr          = '0;
        w_props_lr[114]     = is_static_in;
        w_props_lr[113:112] = shape_in;
        unique case (shape_in)
            2'b01: begin
                w_props_lr[111:96] = {1'b0, x_in_1, 4'b0};
                w_props_lr[95:80]  = {1'b0, y_in_1, 5'b0};
                w_props_lr[63:48]  = {5'b0, x_in_2};
                w_props_lr[47:32]  = {6'b0, y_in_2};
            end
            2'b10: begin
                w_props_lr[111:96] = {1'b0, x_in_1, 4'b0};
                w_props_lr[95:80]  = {1'b0, y_in_1, 5'b0};
                w_props_lr[79:64]  = w_rdx1;
                w_props_lr[63:48]  = w_rdy1;
                w_props_lr[47:32]  = w_rdy2;
            end
            2'b11: w_props_lr = '0;
            default: ;
        endcase
    end

    always_comb begin
        w_props_circ          = '0;
        w_props_circ[114]     = r_static;
        w_props_circ[113:112] = 2'b00;
        w_props_circ[111:96]  = {5'b0, r_x1};
        w_props_circ[95:80]   = {6'b0, r_y1};
        w_props_circ[47:32]   = {{(16-ROOT_BITS){1'b0}}, w_root_nx};
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = (shape_in == 2'b00) ? S_SQUARE : S_OUT;
                end
            end
            S_SQUARE: w_state_nx = S_ROOT;
            S_ROOT: begin
                if (w_last) begin
                    w_state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (ready_in) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_static <= 1'b0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
            r_rad    <= '0;
            r_root   <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_props  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_static <= is_static_in;
                        r_x1     <= x_in_1;
                        r_y1     <= y_in_1;
                        r_x2     <= x_in_2;
                        r_y2     <= y_in_2;
                        if (shape_in != 2'b00) begin
                            r_props <= w_props_lr;
                            r_valid <= 1'b1;
                            r_err   <= (shape_in == 2'b11);
                        end
                    end
                end
                S_SQUARE: begin
                    r_rad  <= w_rad_sq;
                    r_root <= '0;
                    r_rem  <= '0;
                    r_cnt  <= '0;
                end
                S_ROOT: begin
                    r_rad  <= {r_rad[RAD_BITS-3:0], 2'b00};
                    r_rem  <= w_rem_nx;
                    r_root <= w_root_nx;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_props <= w_props_circ;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_OUT: begin
                    if (ready_in) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
